// File: rtl/nv_nvdla_cvif_wr_req_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_cvif_wr_req_pack_pkg
//  Description : Shared CVIF write-request packet layout: packet ids, field
//                offsets/widths, FSM state type and packet builders.
//  Revision    : 1.0  initial release
// ============================================================================
package nv_nvdla_cvif_wr_req_pack_pkg;

  // Field widths
  localparam int unsigned c_ADDR_W       = 64;
  localparam int unsigned c_SIZE_W       = 13;
  localparam int unsigned c_DATA_W       = 512;
  localparam int unsigned c_MASK_W       = 2;

  // Command packet layout
  localparam int unsigned c_CMD_ADDR_LSB = 0;
  localparam int unsigned c_CMD_SIZE_LSB = 64;
  localparam int unsigned c_CMD_ACK_BIT  = 77;
  localparam int unsigned c_CMD_PAD_LSB  = 78;

  // Data packet layout
  localparam int unsigned c_DAT_DATA_LSB = 0;
  localparam int unsigned c_DAT_MASK_LSB = 512;

  // Common packet header
  localparam int unsigned c_PKT_ID_BIT   = 514;
  localparam int unsigned c_PD_W         = 515;

  localparam logic        c_PKT_ID_CMD   = 1'b0;
  localparam logic        c_PKT_ID_DAT   = 1'b1;

  // Full beat carries both 32B atoms; half beat only the lower one
  localparam logic [1:0]  c_MASK_FULL    = 2'b11;
  localparam logic [1:0]  c_MASK_LOW     = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } wr_state_e;

  // Build a command packet; unused upper bits are zero
  function automatic logic [c_PD_W-1:0] pack_cmd(
    input logic [c_ADDR_W-1:0] addr,
    input logic [c_SIZE_W-1:0] size,
    input logic                ack
  );
    logic [c_PD_W-1:0] pd;
    pd                                = '0;
    pd[c_CMD_ADDR_LSB +: c_ADDR_W]    = addr;
    pd[c_CMD_SIZE_LSB +: c_SIZE_W]    = size;
    pd[c_CMD_ACK_BIT]                 = ack;
    pd[c_PKT_ID_BIT]                  = c_PKT_ID_CMD;
    return pd;
  endfunction

  // Build a data packet
  function automatic logic [c_PD_W-1:0] pack_dat(
    input logic [c_DATA_W-1:0] data,
    input logic [c_MASK_W-1:0] mask
  );
    logic [c_PD_W-1:0] pd;
    pd                                = '0;
    pd[c_DAT_DATA_LSB +: c_DATA_W]    = data;
    pd[c_DAT_MASK_LSB +: c_MASK_W]    = mask;
    pd[c_PKT_ID_BIT]                  = c_PKT_ID_DAT;
    return pd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_cvif_wr_req_pack.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_cvif_wr_req_pack
//  Description : Packs a write command and its 64B data beats into the CVIF
//                write-request packet stream; tracks outstanding acks.
//  Revision    : 1.0  initial release
// ============================================================================
module nv_nvdla_cvif_wr_req_pack
  import nv_nvdla_cvif_wr_req_pack_pkg::*;
#(
  parameter int unsigned OS_MAX = 255
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [63:0]    cmd_addr,
  input  logic [12:0]    cmd_size,
  input  logic           cmd_require_ack,
  input  logic           dat_valid,
  output logic           dat_ready,
  input  logic [511:0]   dat_data,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [514:0]   req_pd,
  input  logic           rsp_complete,
  output logic [7:0]     ack_pending,
  output logic           idle
);

  localparam logic [7:0] c_OS_MAX = 8'(OS_MAX);

  wr_state_e     state_q,       state_d;
  logic [12:0]   beat_cnt_q,    beat_cnt_d;
  logic [63:0]   addr_q,        addr_d;
  logic [12:0]   size_q,        size_d;
  logic          ack_q,         ack_d;
  logic [7:0]    ack_pending_q, ack_pending_d;

  logic          w_in_idle;
  logic          w_in_cmd;
  logic          w_in_data;
  logic          w_ack_full;
  logic          w_cmd_accept;
  logic          w_beat_accept;
  logic          w_last_beat;
  logic          w_ack_inc;
  logic          w_ack_dec;
  logic [1:0]    w_mask;

  assign w_in_idle     = (state_q == ST_IDLE);
  assign w_in_cmd      = (state_q == ST_CMD);
  assign w_in_data     = (state_q == ST_DATA);

  // An ack command must wait while the outstanding budget is exhausted
  assign w_ack_full    = cmd_require_ack && (ack_pending_q == c_OS_MAX);
  assign cmd_ready     = w_in_idle && !w_ack_full && !nvdla_core_rst;
  assign w_cmd_accept  = cmd_valid && cmd_ready;

  // Data phase is a straight pass-through of the beat handshake
  assign req_valid     = w_in_cmd || (w_in_data && dat_valid);
  assign dat_ready     = w_in_data && req_ready;
  assign w_beat_accept = w_in_data && dat_valid && req_ready;
  assign w_last_beat   = (beat_cnt_q == 13'd1);

  // Odd atom count leaves the top half of the final beat empty
  assign w_mask        = (w_last_beat && !size_q[0]) ? c_MASK_LOW : c_MASK_FULL;

  // Command fields come from capture registers so they hold under backpressure
  assign req_pd        = w_in_data ? pack_dat(dat_data, w_mask)
                                   : pack_cmd(addr_q, size_q, ack_q);

  // Completions only count against a non-zero balance
  assign w_ack_inc     = w_cmd_accept && cmd_require_ack;
  assign w_ack_dec     = rsp_complete && (ack_pending_q != 8'd0);

  assign ack_pending   = ack_pending_q;
  assign idle          = w_in_idle && (ack_pending_q == 8'd0);

  // Next-state, command capture and beat countdown
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    ack_d      = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cmd_accept) begin
          addr_d  = cmd_addr;
          size_d  = cmd_size;
          ack_d   = cmd_require_ack;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (req_ready) begin
          // Two 32B atoms per 64B beat, rounded up
          beat_cnt_d = {1'b0, size_q[12:1]} + 13'd1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_beat_accept) begin
          beat_cnt_d = beat_cnt_q - 13'd1;
          if (w_last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding-ack balance; simultaneous accept and completion cancel
  always_comb begin
    ack_pending_d = ack_pending_q;
    if (w_ack_inc && !w_ack_dec) begin
      ack_pending_d = ack_pending_q + 8'd1;
    end else if (w_ack_dec && !w_ack_inc) begin
      ack_pending_d = ack_pending_q - 8'd1;
    end
  end

  // State registers; reset abandons any in-flight packet
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= 13'd0;
      addr_q        <= 64'd0;
      size_q        <= 13'd0;
      ack_q         <= 1'b0;
      ack_pending_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      ack_q         <= ack_d;
      ack_pending_q <= ack_pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_cvif_wr_req_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nv_nvdla_cvif_wr_req_pack
//  Description : Directed self-checking bench for the CVIF write-request packer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nv_nvdla_cvif_wr_req_pack;

  logic           clk;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [63:0]    cmd_addr;
  logic [12:0]    cmd_size;
  logic           cmd_require_ack;
  logic           dat_valid;
  logic           dat_ready;
  logic [511:0]   dat_data;
  logic           req_valid;
  logic           req_ready;
  logic [514:0]   req_pd;
  logic           rsp_complete;
  logic [7:0]     ack_pending;
  logic           idle;

  int n_checks;
  int n_err;

  nv_nvdla_cvif_wr_req_pack #(.OS_MAX(2)) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_size        (cmd_size),
    .cmd_require_ack (cmd_require_ack),
    .dat_valid       (dat_valid),
    .dat_ready       (dat_ready),
    .dat_data        (dat_data),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_pd          (req_pd),
    .rsp_complete    (rsp_complete),
    .ack_pending     (ack_pending),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] pat(input int b);
    pat = {16{32'hC0DE_0000 + 32'(b)}};
  endfunction

  function automatic logic [514:0] exp_cmd(input logic [63:0] a, input logic [12:0] s, input logic k);
    exp_cmd = {1'b0, 436'd0, k, s, a};
  endfunction

  function automatic logic [514:0] exp_dat(input logic [1:0] m, input logic [511:0] d);
    exp_dat = {1'b1, m, d};
  endfunction

  task automatic chk(input string tag, input logic [514:0] obs, input logic [514:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full command with no backpressure; nb = expected number of data beats
  task automatic run_cmd(input logic [63:0] a, input logic [12:0] s, input logic k, input int nb);
    logic [1:0] m;
    cmd_valid = 1'b1; cmd_addr = a; cmd_size = s; cmd_require_ack = k;
    req_ready = 1'b1; dat_valid = 1'b0;
    #1 chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("cmd_valid", req_valid, 1);
    chk("cmd_pd", req_pd, exp_cmd(a, s, k));
    chk("cmd_dat_ready", dat_ready, 0);
    tick();
    for (int b = 0; b < nb; b++) begin
      dat_valid = 1'b1;
      dat_data  = pat(b);
      #1;
      m = ((b == nb - 1) && !s[0]) ? 2'b01 : 2'b11;
      chk("dat_pd", req_pd, exp_dat(m, pat(b)));
      chk("dat_ready", dat_ready, 1);
      tick();
    end
    dat_valid = 1'b1;
    #1 chk("end_req_valid", req_valid, 0);
    dat_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_addr = '0; cmd_size = '0; cmd_require_ack = 1'b0;
    dat_valid = 1'b0; dat_data = '0; req_ready = 1'b1; rsp_complete = 1'b0;

    // Reset state
    #3;
    chk("rst_idle", idle, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_dat_ready", dat_ready, 0);
    chk("rst_ack", ack_pending, 0);
    tick();
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1 chk("post_rst_idle", idle, 1);

    // Basic command, odd size, two full beats
    run_cmd(64'h1000, 13'd3, 1'b0, 2);
    chk("basic_idle", idle, 1);

    // Boundary sizes
    run_cmd(64'h40, 13'd0, 1'b0, 1);
    run_cmd(64'h80, 13'd4, 1'b0, 3);

    // Backpressure in CMD and mid-DATA
    cmd_valid = 1'b1; cmd_addr = 64'h2000; cmd_size = 13'd6; cmd_require_ack = 1'b0;
    req_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_cmd_valid", req_valid, 1);
      chk("stall_cmd_pd", req_pd, exp_cmd(64'h2000, 13'd6, 1'b0));
      chk("stall_cmd_dat_ready", dat_ready, 0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    dat_valid = 1'b1; dat_data = pat(0);
    #1 chk("stall_beat0", req_pd, exp_dat(2'b11, pat(0)));
    tick();
    dat_data = pat(1); req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_dat_valid", req_valid, 1);
      chk("stall_dat_pd", req_pd, exp_dat(2'b11, pat(1)));
      chk("stall_dat_ready", dat_ready, 0);
      tick();
    end
    req_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      dat_data = pat(b);
      #1 chk("stall_beat", req_pd, exp_dat((b == 3) ? 2'b01 : 2'b11, pat(b)));
      tick();
    end
    #1 chk("stall_end", req_valid, 0);
    dat_valid = 1'b0;

    // Outstanding ack limit (OS_MAX = 2)
    run_cmd(64'h3000, 13'd0, 1'b1, 1);
    chk("ack_1", ack_pending, 1);
    chk("ack_idle_0", idle, 0);
    run_cmd(64'h3040, 13'd0, 1'b1, 1);
    chk("ack_2", ack_pending, 2);
    cmd_valid = 1'b1; cmd_addr = 64'h3080; cmd_size = 13'd0; cmd_require_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ack_full_ready", cmd_ready, 0);
      tick();
    end
    chk("ack_full_no_req", req_valid, 0);
    rsp_complete = 1'b1;
    tick();
    rsp_complete = 1'b0;
    #1;
    chk("ack_after_rsp", ack_pending, 1);
    chk("ack_ready_again", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("ack_back_2", ack_pending, 2);
    chk("ack_cmd_valid", req_valid, 1);
    req_ready = 1'b1; dat_valid = 1'b1; dat_data = pat(9);
    tick();
    tick();
    dat_valid = 1'b0;
    #1 chk("ack_cmd_done", req_valid, 0);

    // Completion coincident with an ack accept
    rsp_complete = 1'b1;
    tick();
    rsp_complete = 1'b0;
    #1 chk("rsp_dec", ack_pending, 1);
    cmd_valid = 1'b1; cmd_addr = 64'h4000; cmd_size = 13'd0; cmd_require_ack = 1'b1;
    rsp_complete = 1'b1;
    #1 chk("coinc_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; rsp_complete = 1'b0;
    #1 chk("coinc_unchanged", ack_pending, 1);
    dat_valid = 1'b1; dat_data = pat(5);
    tick();
    tick();
    dat_valid = 1'b0;
    rsp_complete = 1'b1;
    tick();
    #1 chk("drain_0", ack_pending, 0);
    tick();
    rsp_complete = 1'b0;
    #1;
    chk("no_wrap", ack_pending, 0);
    chk("drain_idle", idle, 1);

    // Reset during the second of four beats
    cmd_valid = 1'b1; cmd_addr = 64'h5000; cmd_size = 13'd7; cmd_require_ack = 1'b1;
    req_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    dat_valid = 1'b1; dat_data = pat(0);
    tick();
    dat_data = pat(1);
    #1 chk("pre_rst_valid", req_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_valid", req_valid, 0);
    chk("mid_rst_dat_ready", dat_ready, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_ack", ack_pending, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_idle", idle, 1);
    chk("rel_req_valid", req_valid, 0);
    chk("rel_cmd_ready", cmd_ready, 1);
    dat_valid = 1'b0;
    run_cmd(64'h6000, 13'd3, 1'b0, 2);

    // Largest transfer
    run_cmd(64'h7000, 13'd8191, 1'b0, 4096);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
